mult_cell_sched: RTL

Sequencer and round-robin arbiter that shares one registered 16x16 partial-product multiplier cell (three products: lo·lo, lo·hi, hi·lo) between NUM_REQ requesters. Each request is a 32x32 multiply. The block:
- grants one requester,
- drives the cell for one enable cycle,
- folds the three 32-bit partial products into the low 32 bits of the product,
- returns that result to the granted requester over a valid/ready response.

It sits between the cell and client datapaths, for example the CPU custom-instruction port and a DSP/audio engine.

---
 rtl/mult_sched_pkg.sv | 6 +
 rtl/mult_cell_sched_if.sv | 24 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/mult_cell_sched.sv | 72 +++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared widths and sequencer state encoding
package mult_sched_pkg;
    localparam int DATA_W = 32;
    localparam int HALF_W = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, COMBINE, RESP} state_t;
endpackage

// File: rtl/mult_cell_sched_if.sv
// mult_cell_sched_if: request/response bus between client datapaths and the scheduler
interface mult_cell_sched_if
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_src1;
    logic [NUM_REQ*DATA_W-1:0] req_src2;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_ready;
    modport master (
        output req_valid, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );
    modport slave (
        input  req_valid, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting one past the last grant
module rr_arbiter #(
    parameter int N = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx
);
    logic [ID_W-1:0] j;
    always_comb begin
        gnt = '0;
        idx = '0;
        j = '0;
        // walk from farthest to nearest so the nearest requester after last overrides
        for (int k = N; k >= 1; k--) begin
            j = ID_W'((int'(last) + k) % N);
            if (req[j]) begin
                gnt = N'(1) << j;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/mult_cell_sched.sv
// mult_cell_sched: round-robin sequencer sharing one 16x16 partial-product cell among requesters
module mult_cell_sched
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    mult_cell_sched_if.slave  bus,
    output logic [DATA_W-1:0] cell_src1,
    output logic [DATA_W-1:0] cell_src2,
    output logic              cell_en,
    input  logic [DATA_W-1:0] cell_p1,
    input  logic [DATA_W-1:0] cell_p2,
    input  logic [DATA_W-1:0] cell_p3,
    output logic              busy
);
    state_t state, state_n;
    logic [ID_W-1:0] last_grant, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic hs;
    logic [DATA_W-1:0] res;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req  (bus.req_valid),
        .last (last_grant),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        hs = |(bus.req_valid & bus.req_ready);
        state_n = state == IDLE    ? (hs ? ISSUE : IDLE) :
                  state == ISSUE   ? COMBINE :
                  state == COMBINE ? RESP :
                  (bus.rsp_ready ? IDLE : RESP);
    end

    always_comb begin
        cell_en = state == ISSUE;
        busy = state != IDLE;
        bus.rsp_valid = state == RESP;
        bus.req_ready = (state == IDLE && !reset) ? gnt : '0;
    end

    // only the low half of the cross-term sum survives the shift into 32 bits
    assign res = cell_p1 + ((cell_p2 + cell_p3) << HALF_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            cell_src1 <= '0;
            cell_src2 <= '0;
            bus.rsp_id <= '0;
            bus.rsp_data <= '0;
        end else begin
            if (hs) begin
                cell_src1 <= bus.req_src1[DATA_W*gnt_idx +: DATA_W];
                cell_src2 <= bus.req_src2[DATA_W*gnt_idx +: DATA_W];
                bus.rsp_id <= gnt_idx;
                last_grant <= gnt_idx;
            end
            if (state == COMBINE) bus.rsp_data <= res;
        end
    end
endmodule
